rib_wb_bridge: RTL and testbench



---
 rtl/rib_wb_bridge.sv | 154 +++++++++++++++
 tb/tb_rib_wb_bridge.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rib_wb_bridge.sv
// Bridges the tinyriscv data-side RIB request port onto a Wishbone classic master.
// Holds the core while a bus cycle is outstanding and terminates hung cycles after a timeout.
module rib_wb_bridge #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    sys_clk,
  input  logic                    rst_n,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] sel_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    hold_o,
  output logic                    err_o,
  output logic                    cyc_o,
  output logic                    stb_o,
  output logic                    we_o,
  output logic [DATA_WIDTH/8-1:0] sel_o,
  output logic [ADDR_WIDTH-1:0]   addr_o,
  output logic [DATA_WIDTH-1:0]   data_o,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic                    ack_i
);

  localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned CNT_WIDTH = (TIMEOUT_CYCLES > 32'd0) ? $clog2(TIMEOUT_CYCLES + 32'd1) : 1;
  localparam logic [CNT_WIDTH:0]   TO_LIMIT = (CNT_WIDTH + 1)'(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_cyc,   w_cyc_nxt;
  logic                    r_we,    w_we_nxt;
  logic [SEL_WIDTH-1:0]    r_sel,   w_sel_nxt;
  logic [ADDR_WIDTH-1:0]   r_addr,  w_addr_nxt;
  logic [DATA_WIDTH-1:0]   r_data,  w_data_nxt;
  logic [DATA_WIDTH-1:0]   r_rdata, w_rdata_nxt;
  logic                    r_err,   w_err_nxt;
  logic [CNT_WIDTH-1:0]    r_cnt,   w_cnt_nxt;
  logic [CNT_WIDTH:0]      w_cnt_inc;
  logic                    w_timeout;

  // The count of completed BUS cycles reaches the limit at the end of BUS cycle TIMEOUT_CYCLES.
  assign w_cnt_inc = {1'b0, r_cnt} + {{CNT_WIDTH{1'b0}}, 1'b1};
  assign w_timeout = (TIMEOUT_CYCLES != 32'd0) && (w_cnt_inc == TO_LIMIT);

  // FSM state register
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next bus/response register values
  always_comb begin
    w_state_nxt = r_state;
    w_cyc_nxt   = r_cyc;
    w_we_nxt    = r_we;
    w_sel_nxt   = r_sel;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_rdata_nxt = r_rdata;
    w_err_nxt   = 1'b0;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (req_i) begin
          w_we_nxt    = we_i;
          w_sel_nxt   = sel_i;
          w_addr_nxt  = addr_i;
          w_data_nxt  = wdata_i;
          w_cyc_nxt   = 1'b1;
          w_cnt_nxt   = {CNT_WIDTH{1'b0}};
          w_state_nxt = ST_BUS;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUS: begin
        if (ack_i) begin
          if (!r_we) begin
            w_rdata_nxt = data_i;
          end else begin
            w_rdata_nxt = r_rdata;
          end
          w_cyc_nxt   = 1'b0;
          w_state_nxt = ST_RESP;
        end else if (w_timeout) begin
          w_rdata_nxt = {DATA_WIDTH{1'b0}};
          w_cyc_nxt   = 1'b0;
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_RESP;
        end else if (r_cnt != CNT_MAX) begin
          w_cnt_nxt = w_cnt_inc[CNT_WIDTH-1:0];
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      // The core still presents the finished request here, so req_i must not re-issue it.
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_cyc_nxt   = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Bus, response and timeout registers
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc   <= 1'b0;
      r_we    <= 1'b0;
      r_sel   <= {SEL_WIDTH{1'b0}};
      r_addr  <= {ADDR_WIDTH{1'b0}};
      r_data  <= {DATA_WIDTH{1'b0}};
      r_rdata <= {DATA_WIDTH{1'b0}};
      r_err   <= 1'b0;
      r_cnt   <= {CNT_WIDTH{1'b0}};
    end else begin
      r_cyc   <= w_cyc_nxt;
      r_we    <= w_we_nxt;
      r_sel   <= w_sel_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_rdata <= w_rdata_nxt;
      r_err   <= w_err_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign hold_o  = ((r_state == ST_IDLE) && req_i) || (r_state == ST_BUS);
  assign cyc_o   = r_cyc;
  assign stb_o   = r_cyc;
  assign we_o    = r_we;
  assign sel_o   = r_sel;
  assign addr_o  = r_addr;
  assign data_o  = r_data;
  assign rdata_o = r_rdata;
  assign err_o   = r_err;

endmodule

// File: tb/tb_rib_wb_bridge.sv
// Scoreboard bench for rib_wb_bridge: stimulus queues expected bus requests and core
// responses, a negedge monitor pops and compares them as the DUT presents them.
module tb_rib_wb_bridge;

  logic        sys_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic        req     = 1'b0;
  logic        we      = 1'b0;
  logic [31:0] addr    = 32'd0;
  logic [31:0] wdata   = 32'd0;
  logic [3:0]  sel     = 4'd0;
  logic [31:0] dat_i   = 32'd0;
  logic        ack     = 1'b0;
  logic        en4     = 1'b0;
  logic        req4;

  logic [31:0] rdata, data_o, addr_o;
  logic [3:0]  sel_o;
  logic        hold, err, cyc, stb, we_o;
  logic [31:0] rdata4, data_o4, addr_o4;
  logic [3:0]  sel_o4;
  logic        hold4, err4, cyc4, stb4, we_o4;

  assign req4 = req & en4;

  always #5 sys_clk = ~sys_clk;

  rib_wb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .sel_i(sel), .rdata_o(rdata), .hold_o(hold), .err_o(err),
    .cyc_o(cyc), .stb_o(stb), .we_o(we_o), .sel_o(sel_o), .addr_o(addr_o),
    .data_o(data_o), .data_i(dat_i), .ack_i(ack)
  );

  rib_wb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut4 (
    .sys_clk(sys_clk), .rst_n(rst_n), .req_i(req4), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .sel_i(sel), .rdata_o(rdata4), .hold_o(hold4), .err_o(err4),
    .cyc_o(cyc4), .stb_o(stb4), .we_o(we_o4), .sel_o(sel_o4), .addr_o(addr_o4),
    .data_o(data_o4), .data_i(dat_i), .ack_i(ack)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
  } bus_exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_exp_t;

  bus_exp_t bus_q[$];
  rsp_exp_t rsp_q[$];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic mid();
    @(negedge sys_clk);
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus_exp_t be;
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    sel   = s;
    be.we = w; be.addr = a; be.sel = s; be.data = d;
    bus_q.push_back(be);
  endtask

  task automatic expect_rsp(input logic [31:0] rd, input logic e);
    rsp_exp_t re;
    re.rdata = rd;
    re.err   = e;
    rsp_q.push_back(re);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk1({tag, "_cyc"}, cyc, 1'b0);
    chk1({tag, "_stb"}, stb, 1'b0);
    chk1({tag, "_we"}, we_o, 1'b0);
    chk32({tag, "_sel"}, {28'd0, sel_o}, 32'd0);
    chk32({tag, "_addr"}, addr_o, 32'd0);
    chk32({tag, "_data"}, data_o, 32'd0);
    chk32({tag, "_rdata"}, rdata, 32'd0);
    chk1({tag, "_err"}, err, 1'b0);
  endtask

  // Monitor: a rising stb is a new bus request, a falling hold is a core response.
  initial begin
    logic     prev_stb;
    logic     prev_hold;
    bus_exp_t be;
    rsp_exp_t re;
    prev_stb  = 1'b0;
    prev_hold = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (!rst_n) begin
        prev_stb  = 1'b0;
        prev_hold = 1'b0;
      end else begin
        if (stb && !prev_stb) begin
          if (bus_q.size() == 0) begin
            chk1("unexpected_stb", 1'b1, 1'b0);
          end else begin
            be = bus_q.pop_front();
            chk1("bus_cyc", cyc, 1'b1);
            chk32("bus_addr", addr_o, be.addr);
            chk1("bus_we", we_o, be.we);
            chk32("bus_sel", {28'd0, sel_o}, {28'd0, be.sel});
            if (be.we) chk32("bus_wdata", data_o, be.data);
          end
        end
        if (prev_hold && !hold) begin
          if (rsp_q.size() == 0) begin
            chk1("unexpected_rsp", 1'b1, 1'b0);
          end else begin
            re = rsp_q.pop_front();
            chk32("rsp_rdata", rdata, re.rdata);
            chk1("rsp_err", err, re.err);
          end
        end
        prev_stb  = stb;
        prev_hold = hold;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n_stb;
    bit  released;

    // Reset state
    #3;
    check_reset_outputs("rst0");
    chk1("rst0_hold", hold, 1'b0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;

    // Single read, zero-wait
    next_cycle();
    issue(1'b0, 32'h0000_1000, 32'h0, 4'hF);
    expect_rsp(32'hCAFE_BABE, 1'b0);
    mid();
    chk1("rd_c0_hold", hold, 1'b1);
    chk1("rd_c0_stb", stb, 1'b0);
    next_cycle();
    ack = 1'b1; dat_i = 32'hCAFE_BABE;
    mid();
    chk1("rd_c1_stb", stb, 1'b1);
    chk1("rd_c1_hold", hold, 1'b1);
    next_cycle();
    ack = 1'b0;
    mid();
    chk1("rd_c2_stb", stb, 1'b0);
    chk1("rd_c2_hold", hold, 1'b0);
    next_cycle();
    req = 1'b0;
    mid();
    chk1("rd_c3_stb", stb, 1'b0);

    // Write, 3 wait states; core inputs are scrambled mid-cycle to prove the bus side is latched
    next_cycle();
    issue(1'b1, 32'h0000_2004, 32'h1234_5678, 4'b0011);
    expect_rsp(32'hCAFE_BABE, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      if (c >= 2) begin
        addr = 32'hFFFF_FFFC; wdata = 32'h0; sel = 4'hF; we = 1'b0;
      end
      if (c == 4) begin
        ack = 1'b1; dat_i = 32'hDEAD_BEEF;
      end
      mid();
      chk1("wr_stb", stb, 1'b1);
      chk32("wr_addr", addr_o, 32'h0000_2004);
      chk32("wr_data", data_o, 32'h1234_5678);
      chk32("wr_sel", {28'd0, sel_o}, 32'h0000_0003);
      chk1("wr_we", we_o, 1'b1);
    end
    next_cycle();
    ack = 1'b0;
    mid();
    chk1("wr_c5_hold", hold, 1'b0);
    next_cycle();
    req = 1'b0;

    // Timeout after 8 BUS cycles with no ack
    next_cycle();
    issue(1'b0, 32'h0000_4000, 32'h0, 4'hF);
    expect_rsp(32'h0000_0000, 1'b1);
    dat_i = 32'h1111_1111;
    n_stb = 0;
    released = 1'b0;
    for (int c = 1; c <= 20 && !released; c++) begin
      next_cycle();
      mid();
      if (stb) n_stb++;
      if (!hold) begin
        released = 1'b1;
        chk1("to_err_pulse", err, 1'b1);
      end
    end
    chk32("to_stb_cycles", n_stb, 32'd8);
    chk1("to_released", released, 1'b1);
    next_cycle();
    req = 1'b0;
    mid();
    chk1("to_err_one_cycle", err, 1'b0);
    chk1("to_idle_stb", stb, 1'b0);
    chk1("to_idle_hold", hold, 1'b0);

    // Ack coincident with timeout on a TIMEOUT_CYCLES=4 bridge
    next_cycle();
    en4 = 1'b1;
    issue(1'b0, 32'h0000_5000, 32'h0, 4'hF);
    expect_rsp(32'h55AA_55AA, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      if (c == 4) begin
        ack = 1'b1; dat_i = 32'h55AA_55AA;
      end
      mid();
      chk1("co_stb4", stb4, 1'b1);
      chk1("co_err4_bus", err4, 1'b0);
    end
    next_cycle();
    ack = 1'b0;
    mid();
    chk1("co_hold4", hold4, 1'b0);
    chk1("co_err4", err4, 1'b0);
    chk32("co_rdata4", rdata4, 32'h55AA_55AA);
    chk1("co_stb4_resp", stb4, 1'b0);
    next_cycle();
    req = 1'b0;
    en4 = 1'b0;

    // Back-to-back: request held through RESP, plus a spurious ack in IDLE
    next_cycle();
    issue(1'b0, 32'h0000_6000, 32'h0, 4'hF);
    expect_rsp(32'h0BAD_F00D, 1'b0);
    next_cycle();
    ack = 1'b1; dat_i = 32'h0BAD_F00D;
    next_cycle();
    ack = 1'b0;
    issue(1'b0, 32'h0000_3000, 32'h0, 4'hF);
    expect_rsp(32'h7777_8888, 1'b0);
    mid();
    chk1("b2b_resp_stb", stb, 1'b0);
    chk1("b2b_resp_hold", hold, 1'b0);
    next_cycle();
    ack = 1'b1; dat_i = 32'hFFFF_FFFF;
    mid();
    chk1("b2b_idle_stb", stb, 1'b0);
    chk1("b2b_idle_hold", hold, 1'b1);
    next_cycle();
    ack = 1'b0;
    mid();
    chk1("b2b_second_stb", stb, 1'b1);
    chk32("b2b_spurious_rdata", rdata, 32'h0BAD_F00D);
    next_cycle();
    ack = 1'b1; dat_i = 32'h7777_8888;
    next_cycle();
    ack = 1'b0;
    mid();
    chk1("b2b_second_hold", hold, 1'b0);
    next_cycle();
    req = 1'b0;

    // Reset mid-BUS, then a normal read
    next_cycle();
    issue(1'b1, 32'h0000_7000, 32'hAAAA_5555, 4'hF);
    next_cycle();
    mid();
    chk1("rm_c1_stb", stb, 1'b1);
    next_cycle();
    mid();
    chk1("rm_c2_stb", stb, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rm");
    chk1("rm_hold_req", hold, 1'b1);
    req = 1'b0;
    #1;
    chk1("rm_hold_noreq", hold, 1'b0);
    mid();
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    issue(1'b0, 32'h0000_8000, 32'h0, 4'hF);
    expect_rsp(32'h1357_9BDF, 1'b0);
    next_cycle();
    ack = 1'b1; dat_i = 32'h1357_9BDF;
    next_cycle();
    ack = 1'b0;
    mid();
    chk1("rm_post_hold", hold, 1'b0);
    next_cycle();
    req = 1'b0;
    next_cycle();
    mid();

    chk32("bus_q_drained", bus_q.size(), 32'd0);
    chk32("rsp_q_drained", rsp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
